// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: state codes, opcode/funct
// values, datapath select encodings and the decoder/strobe bundles.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR} cls_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PCN_SEQ  = 2'd0;
  localparam logic [1:0] PCN_JUMP = 2'd1;
  localparam logic [1:0] PCN_REG  = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] RI_ALU = 2'd0;
  localparam logic [1:0] RI_MDR = 2'd1;
  localparam logic [1:0] RI_PC  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  typedef struct packed {
    logic       legal;
    cls_e       cls;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic [1:0] reg_dst;
  } dec_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_sel;
    logic       mem_we;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_next;
    logic       branch_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_in;
    logic       alu_src;
    logic [2:0] alu_ctrl;
  } ctl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared single-port memory handshake between the sequencer and the memory.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_sel;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_sel, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_sel, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_controller_main_decoder.sv
// Combinational op/funct decode into instruction class and the ALU/dest selects.
module main_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.legal    = 1'b1;
    dec.cls      = C_ALU;
    dec.alu_ctrl = ALU_ADD;
    dec.alu_src  = 1'b0;
    dec.reg_dst  = RD_RT;
    case (op)
      OP_R: begin
        dec.alu_src = 1'b1;
        dec.reg_dst = RD_RD;
        case (funct)
          FN_ADD:  dec.alu_ctrl = ALU_ADD;
          FN_SUB:  dec.alu_ctrl = ALU_SUB;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          FN_JR:   dec.cls      = C_JR;
          default: dec.legal    = 1'b0;
        endcase
      end
      OP_LW:   dec.cls = C_LW;
      OP_SW:   dec.cls = C_SW;
      OP_ADDI: dec.alu_ctrl = ALU_ADD;
      OP_XORI: dec.alu_ctrl = ALU_XOR;
      OP_BEQ: begin
        dec.cls      = C_BEQ;
        dec.alu_ctrl = ALU_SUB;
        dec.alu_src  = 1'b1;
      end
      OP_BNE: begin
        dec.cls      = C_BNE;
        dec.alu_ctrl = ALU_SUB;
        dec.alu_src  = 1'b1;
      end
      OP_J:    dec.cls = C_J;
      OP_JAL: begin
        dec.cls     = C_JAL;
        dec.reg_dst = RD_RA;
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: state register, memory watchdog, retire counter and
// per-state strobe decode for the CPU datapath.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                op,
  input  logic [5:0]                funct,
  input  logic                      alu_zero,
  multicycle_controller_if.master   mem,
  output logic                      ir_we,
  output logic                      mdr_we,
  output logic                      pc_we,
  output logic [1:0]                pc_next,
  output logic                      branch_sel,
  output logic                      reg_we,
  output logic [1:0]                reg_dst,
  output logic [1:0]                reg_in,
  output logic                      alu_src,
  output logic [2:0]                alu_ctrl,
  output logic [2:0]                state,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      retired
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e          cur, nxt;
  dec_t            dec;
  ctl_t            c, ctl;
  logic            retire, waiting;
  logic [WD_W-1:0] wd;

  main_decoder u_dec (.op(op), .funct(funct), .dec(dec));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      wd      <= '0;
      retired <= '0;
    end else begin
      cur <= nxt;
      wd  <= (WD_EN && waiting) ? wd + 1'b1 : '0;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt    = cur;
    c      = '0;
    retire = 1'b0;
    case (cur)
      S_FETCH: begin
        c.mem_req = 1'b1;
        if (mem.mem_ready) begin
          c.ir_we = 1'b1;
          c.pc_we = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: nxt = dec.legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        nxt    = S_FETCH;
        retire = 1'b1;
        case (dec.cls)
          C_ALU: begin
            c.alu_src  = dec.alu_src;
            c.alu_ctrl = dec.alu_ctrl;
            nxt        = S_WB;
            retire     = 1'b0;
          end
          // Address add: the all-zero defaults already select ADD with seImm.
          C_LW, C_SW: begin
            nxt    = S_MEM;
            retire = 1'b0;
          end
          C_BEQ, C_BNE: begin
            c.alu_src    = dec.alu_src;
            c.alu_ctrl   = dec.alu_ctrl;
            c.branch_sel = 1'b1;
            c.pc_we      = alu_zero ^ (dec.cls == C_BNE);
          end
          C_J: begin
            c.pc_we   = 1'b1;
            c.pc_next = PCN_JUMP;
          end
          C_JAL: begin
            c.pc_we   = 1'b1;
            c.pc_next = PCN_JUMP;
            c.reg_we  = 1'b1;
            c.reg_dst = dec.reg_dst;
            c.reg_in  = RI_PC;
          end
          C_JR: begin
            c.pc_we   = 1'b1;
            c.pc_next = PCN_REG;
          end
        endcase
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.mem_sel = 1'b1;
        c.mem_we  = (dec.cls == C_SW);
        if (mem.mem_ready) begin
          if (dec.cls == C_SW) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else begin
            c.mdr_we = 1'b1;
            nxt      = S_WB;
          end
        end
      end
      S_WB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = dec.reg_dst;
        c.reg_in  = (dec.cls == C_LW) ? RI_MDR : RI_ALU;
        nxt       = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
    waiting = c.mem_req & ~mem.mem_ready;
    if (WD_EN && waiting && (wd == WD_LAST)) nxt = S_HALT;
  end

  // Strobes are forced low on the reset cycle so an in-flight access is dropped.
  assign ctl = reset ? '0 : c;

  assign mem.mem_req = ctl.mem_req;
  assign mem.mem_sel = ctl.mem_sel;
  assign mem.mem_we  = ctl.mem_we;
  assign ir_we       = ctl.ir_we;
  assign mdr_we      = ctl.mdr_we;
  assign pc_we       = ctl.pc_we;
  assign pc_next     = ctl.pc_next;
  assign branch_sel  = ctl.branch_sel;
  assign reg_we      = ctl.reg_we;
  assign reg_dst     = ctl.reg_dst;
  assign reg_in      = ctl.reg_in;
  assign alu_src     = ctl.alu_src;
  assign alu_ctrl    = ctl.alu_ctrl;
  assign state       = cur;
  assign halted      = (cur == S_HALT);

endmodule
